// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame loader and the circular display shifter.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        HUNT,
        LOAD,
        CHECK,
        COMMIT
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Byte i at [8*i +: 8]; also the shifter's power-on pattern.
    localparam logic [127:0] RESET_IMAGE = 128'h00000000_102040FF_FF402010_00000000;

    function automatic logic [31:0] checksum_add(
        input logic [31:0] sum,
        input logic [31:0] data,
        input int unsigned width
    );
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (sum + data) & mask;
    endfunction

endpackage

// File: rtl/uart_frame_loader_timer.sv
// Inter-byte idle counter: clear has priority, counts while enabled, saturates at terminal count.
module frame_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] L_TERM = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != L_TERM)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_terminal = (r_count == L_TERM);

endmodule

// File: rtl/uart_frame_loader.sv
// Framed byte-stream loader: hunts for sync, collects SIZE bytes plus checksum, commits atomically.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int unsigned      WIDTH          = 8,
    parameter int unsigned      SIZE           = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD      = WIDTH'(SYNC_WORD_DEFAULT),
    parameter int unsigned      TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH*SIZE-1:0]   frame_out,
    output logic                    frame_update,
    output logic                    err_checksum,
    output logic                    err_timeout,
    output logic                    busy
);

    localparam int unsigned IW = $clog2(SIZE);
    localparam logic [IW-1:0] L_LAST = IW'(SIZE - 1);
    localparam logic [WIDTH*SIZE-1:0] L_RESET_IMAGE = (WIDTH*SIZE)'(RESET_IMAGE);

    state_t                  r_state, w_state_next;
    logic [WIDTH*SIZE-1:0]   r_shadow, r_frame;
    logic [IW-1:0]           r_index;
    logic [WIDTH-1:0]        r_sum, w_sum_next;
    logic                    r_update, r_err_cs, r_err_to;
    logic                    w_update_next, w_err_cs_next, w_err_to_next;
    logic                    w_accept, w_in_frame, w_timeout;

    assign in_ready   = (r_state != COMMIT);
    assign busy       = (r_state != HUNT);
    assign w_accept   = in_valid && in_ready;
    assign w_in_frame = (r_state == LOAD) || (r_state == CHECK);
    assign w_sum_next = WIDTH'(checksum_add(32'(r_sum), 32'(in_data), WIDTH));

    frame_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept || !w_in_frame),
        .i_enable  (w_in_frame),
        .o_terminal(w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_update <= 1'b0;
            r_err_cs <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_update <= w_update_next;
            r_err_cs <= w_err_cs_next;
            r_err_to <= w_err_to_next;
        end
    end

    // An accepted byte always takes precedence over a coincident timeout.
    always_comb begin
        w_state_next  = r_state;
        w_update_next = 1'b0;
        w_err_cs_next = 1'b0;
        w_err_to_next = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_accept && (in_data == SYNC_WORD)) w_state_next = LOAD;
            end
            LOAD: begin
                if (w_accept) begin
                    if (r_index == L_LAST) w_state_next = CHECK;
                end else if (w_timeout) begin
                    w_state_next  = HUNT;
                    w_err_to_next = 1'b1;
                end
            end
            CHECK: begin
                if (w_accept) begin
                    if (in_data == r_sum) begin
                        w_state_next = COMMIT;
                    end else begin
                        w_state_next  = HUNT;
                        w_err_cs_next = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next  = HUNT;
                    w_err_to_next = 1'b1;
                end
            end
            COMMIT: begin
                w_state_next  = HUNT;
                w_update_next = 1'b1;
            end
            default: w_state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_index  <= '0;
            r_sum    <= '0;
            r_frame  <= L_RESET_IMAGE;
        end else begin
            if (w_accept) begin
                case (r_state)
                    HUNT: begin
                        if (in_data == SYNC_WORD) begin
                            r_index <= '0;
                            r_sum   <= '0;
                        end
                    end
                    LOAD: begin
                        r_shadow[WIDTH*r_index +: WIDTH] <= in_data;
                        r_sum <= w_sum_next;
                        if (r_index != L_LAST) r_index <= r_index + IW'(1);
                    end
                    default: ;
                endcase
            end
            if (r_state == COMMIT) r_frame <= r_shadow;
        end
    end

    assign frame_out    = r_frame;
    assign frame_update = r_update;
    assign err_checksum = r_err_cs;
    assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader: directed tables, hand sequences and random frames vs a stream model.
module tb_uart_frame_loader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SIZE  = 16;
    localparam int unsigned TMO   = 16;
    localparam logic [7:0]  SYNC  = 8'hA5;

    typedef logic [7:0] payload_t [16];

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] cs_xor;
        bit         exp_commit;
        bit         exp_cs_err;
    } frame_vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] frame_out;
    logic         frame_update, err_checksum, err_timeout, busy;

    uart_frame_loader #(
        .WIDTH(WIDTH),
        .SIZE(SIZE),
        .SYNC_WORD(SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .frame_out(frame_out),
        .frame_update(frame_update),
        .err_checksum(err_checksum),
        .err_timeout(err_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Stream-level reference: payload kept as a queue, checksum summed over it when the check byte arrives.
    logic [7:0]   m_q[$];
    bit           m_active, m_commit;
    int           m_idle;
    logic [127:0] m_image;
    bit           e_upd, e_cs, e_to;

    function automatic logic [127:0] reset_img();
        logic [7:0]   rb [16];
        logic [127:0] img;
        rb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'hFF,
               8'hFF, 8'h40, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) img[8*i +: 8] = rb[i];
        return img;
    endfunction

    function automatic logic [127:0] to_img(input payload_t p);
        logic [127:0] img;
        for (int i = 0; i < 16; i++) img[8*i +: 8] = p[i];
        return img;
    endfunction

    function automatic logic [7:0] sum_of(input payload_t p);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(p[i]);
        return 8'(s % 256);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0;
        m_commit = 0;
        m_idle   = 0;
        m_image  = reset_img();
        e_upd = 0; e_cs = 0; e_to = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, output bit acc);
        int s;
        acc = v && !m_commit;
        e_upd = 0; e_cs = 0; e_to = 0;
        if (m_commit) begin
            for (int i = 0; i < 16; i++) m_image[8*i +: 8] = m_q[i];
            e_upd = 1;
            m_commit = 0;
        end else if (m_active) begin
            if (acc) begin
                m_idle = 0;
                if (m_q.size() < SIZE) begin
                    m_q.push_back(d);
                end else begin
                    s = 0;
                    foreach (m_q[i]) s += int'(m_q[i]);
                    m_active = 0;
                    if (d == 8'(s % 256)) m_commit = 1;
                    else e_cs = 1;
                end
            end else begin
                m_idle++;
                if (m_idle >= TMO) begin
                    e_to = 1;
                    m_active = 0;
                end
            end
        end else if (acc && d == SYNC) begin
            m_active = 1;
            m_q.delete();
            m_idle = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", in_ready, !m_commit);
        chk("busy", busy, m_active || m_commit);
        chk("frame_update", frame_update, e_upd);
        chk("err_checksum", err_checksum, e_cs);
        chk("err_timeout", err_timeout, e_to);
        chk("frame_out", frame_out, m_image);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, output bit acc);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step(v, d, acc);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cycle(1'b0, 8'($urandom), acc);
    endtask

    task automatic send_byte(input logic [7:0] d, output int tries);
        bit acc = 0;
        tries = 0;
        while (!acc && tries < 8) begin
            cycle(1'b1, d, acc);
            tries++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input payload_t p, input logic [7:0] cs);
        int t;
        send_byte(SYNC, t);
        for (int i = 0; i < 16; i++) send_byte(p[i], t);
        send_byte(cs, t);
    endtask

    task automatic rand_gap();
        int g;
        g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(13, 18)) : int'($urandom_range(0, 1));
        idle(g);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        frame_vec_t   tbl [4];
        payload_t     p;
        logic [127:0] prev_img;
        logic [7:0]   cs;
        bit           acc, saw_cs, saw_upd;
        int           t, k, first;

        tbl[0] = '{base: 8'hFF, step: 8'h00, cs_xor: 8'hF0, exp_commit: 0, exp_cs_err: 1};
        tbl[1] = '{base: 8'h10, step: 8'h03, cs_xor: 8'h00, exp_commit: 1, exp_cs_err: 0};
        tbl[2] = '{base: 8'hA5, step: 8'h00, cs_xor: 8'h01, exp_commit: 0, exp_cs_err: 1};
        tbl[3] = '{base: 8'h00, step: 8'h00, cs_xor: 8'h00, exp_commit: 1, exp_cs_err: 0};

        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, acc);
        chk("reset byte4", frame_out[39:32], 8'h10);
        chk("reset byte7", frame_out[63:56], 8'hFF);
        chk("reset byte11", frame_out[95:88], 8'h10);
        chk("reset byte0", frame_out[7:0], 8'h00);

        // Good frame 01..10 with hand-computed checksum 0x88.
        for (int i = 0; i < 16; i++) p[i] = 8'(i + 1);
        send_frame(p, 8'h88);
        chk("commit ready low", in_ready, 1'b0);
        chk("commit no early update", frame_update, 1'b0);
        cycle(1'b0, 8'h00, acc);
        chk("commit update pulse", frame_update, 1'b1);
        chk("commit ready back", in_ready, 1'b1);
        for (int i = 0; i < 16; i++) chk("commit byte", frame_out[8*i +: 8], 8'(i + 1));
        cycle(1'b0, 8'h00, acc);
        chk("update one cycle", frame_update, 1'b0);
        prev_img = to_img(p);

        foreach (tbl[v]) begin
            for (int i = 0; i < 16; i++) p[i] = 8'(tbl[v].base + 8'(i) * tbl[v].step);
            send_frame(p, sum_of(p) ^ tbl[v].cs_xor);
            saw_cs = err_checksum;
            cycle(1'b0, 8'h00, acc);
            saw_upd = frame_update;
            chk("tbl cs_err", saw_cs, tbl[v].exp_cs_err);
            chk("tbl commit", saw_upd, tbl[v].exp_commit);
            if (tbl[v].exp_commit) prev_img = to_img(p);
            chk("tbl image", frame_out, prev_img);
            idle(1);
        end

        // Leading garbage, then a payload carrying the sync value at index 3.
        send_byte(8'h00, t);
        send_byte(8'h37, t);
        for (int i = 0; i < 16; i++) p[i] = 8'(i * 7 + 3);
        p[3] = SYNC;
        send_frame(p, sum_of(p));
        idle(1);
        chk("hunt byte3", frame_out[31:24], 8'hA5);
        chk("hunt image", frame_out, to_img(p));
        prev_img = to_img(p);

        // Timeout: err_timeout appears 16 edges after the last accept.
        send_byte(SYNC, t);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i), t);
        first = 0;
        k = 0;
        while (first == 0 && k < 40) begin
            cycle(1'b0, 8'h00, acc);
            k++;
            if (err_timeout) first = k;
        end
        chk("timeout latency", first, 16);
        chk("timeout busy", busy, 1'b0);
        chk("timeout image", frame_out, prev_img);

        // A byte on the terminal edge keeps the frame alive.
        send_byte(SYNC, t);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), t);
        idle(15);
        send_byte(8'h42, t);
        chk("terminal no timeout", err_timeout, 1'b0);
        chk("terminal busy", busy, 1'b1);
        idle(20);

        // Back-pressure across COMMIT, then reset mid-LOAD.
        for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
        send_frame(p, sum_of(p));
        send_byte(SYNC, t);
        chk("backpressure tries", t, 2);
        chk("backpressure image", frame_out, to_img(p));
        chk("backpressure busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'(i), t);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset image", frame_out, reset_img());
        chk("async reset busy", busy, 1'b0);
        chk("async reset ready", in_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 8'h00, acc);

        // Random frames with gaps, garbage and corrupt checksums.
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) cycle(1'b1, 8'($urandom), acc);
            for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
            cs = sum_of(p);
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            rand_gap();
            send_byte(SYNC, t);
            for (int i = 0; i < 16; i++) begin
                rand_gap();
                send_byte(p[i], t);
            end
            rand_gap();
            send_byte(cs, t);
            idle(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Writer side of the rotating pattern buffer. Takes a byte stream from the UART receiver over a valid/ready handshake.
- Assembles framed packets of SIZE payload bytes plus a checksum byte.
- Commits a good frame atomically to a flat WIDTH*SIZE output image that feeds the circular display shifter. Bad or stalled frames are dropped, and the previous image is held.

Parameters:
- WIDTH, 8, bits per payload byte, checksum and sync word.
- SIZE, 16, payload bytes per frame. Power of two, at least 2.
- SYNC_WORD, 8'hA5, header value that starts a frame.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes inside a frame. Must be at least 2.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, WIDTH, byte from the UART receiver.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, loader can accept a byte.
- frame_out, output, WIDTH*SIZE, committed image. Byte i sits at [WIDTH*i +: WIDTH].
- frame_update, output, 1, one-cycle pulse when frame_out changes.
- err_checksum, output, 1, one-cycle pulse on checksum mismatch.
- err_timeout, output, 1, one-cycle pulse on inter-byte timeout.
- busy, output, 1, high in LOAD, CHECK and COMMIT.

Behaviour:
- Reset is asynchronous, active-low, on clk and rst_n. Reset values:
  - state HUNT
  - frame_out = RESET_IMAGE, bytes 0..15 = 00,00,00,00,10,20,40,FF,FF,40,20,10,00,00,00,00
  - shadow buffer = 0
  - index = 0, sum = 0, timer = 0
  - all pulse outputs 0
  - in_ready = 1, busy = 0
- Accept rule: a byte is accepted on the posedge where in_valid && in_ready. in_ready = (state != COMMIT), decoded combinationally from the state.
- HUNT:
  - Accepted byte == SYNC_WORD → LOAD, index = 0, sum = 0, timer = 0.
  - Any other byte is discarded.
- LOAD:
  - Accepted byte is written to shadow[index], sum = (sum + byte) mod 2^WIDTH, index++.
  - On the byte accepted with index == SIZE-1 → CHECK.
  - SYNC_WORD inside the payload is ordinary data. There is no resync.
- CHECK:
  - The accepted byte is the checksum.
  - Equal to sum → COMMIT.
  - Not equal → err_checksum = 1 for the following cycle, → HUNT. frame_out is unchanged.
- COMMIT (exactly one cycle):
  - in_ready = 0.
  - At the next edge, frame_out <= shadow (whole image in one edge), frame_update = 1 for one cycle, → HUNT.
- Latency: checksum accepted at edge N. frame_out is new and frame_update is high after edge N+1. frame_update deasserts after edge N+2.
- Timeout (LOAD and CHECK only):
  - timer clears on each accepted byte and otherwise increments.
  - When timer reaches TIMEOUT_CYCLES-1 with no byte accepted that cycle: err_timeout = 1 for one cycle, → HUNT, shadow contents are ignored.
  - A byte accepted on that same edge wins: it is processed and there is no timeout.
  - The timer does not run in HUNT.
- A frame_out update is never partial. Between commits frame_out is stable.
- The pulse outputs are mutually exclusive by construction.
- Reset mid-frame: the frame is abandoned and frame_out returns to RESET_IMAGE.
- Widths:
  - index is $clog2(SIZE) bits, with no wrap beyond SIZE-1.
  - timer is $clog2(TIMEOUT_CYCLES) bits and saturates at the threshold.

Decomposition:
- Package uart_frame_pkg holds:
  - state enum: HUNT, LOAD, CHECK, COMMIT
  - SYNC_WORD default
  - RESET_IMAGE constant, shared with the circular shifter reset image
  - checksum-accumulate function
- One sub-module, frame_idle_timer, provides a clear/enable counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES.
- The FSM, shadow buffer and output register live in the top block.

Test Plan:
- Reset: release rst_n.
  - frame_out byte4 = 10, byte7 = FF, byte11 = 10, others 00.
  - in_ready = 1, busy = 0, no pulses.
- Good frame: send A5, bytes 01..10 (sum 0x88), then 88.
  - One cycle after the checksum handshake, frame_out byte i = i+1 and frame_update pulses once.
  - in_ready is 0 for exactly that COMMIT cycle.
- Bad checksum: send A5, sixteen 0xFF, then 0x00 (expected 0xF0).
  - err_checksum pulses once and frame_out is unchanged.
  - A following good frame still loads.
- Hunt and in-payload sync: send 00,37,A5, then payload containing A5 at index 3, then the correct checksum.
  - Leading garbage is ignored and the frame commits with byte3 = A5.
- Timeout with TIMEOUT_CYCLES = 16: send A5 plus 5 bytes, then idle.
  - err_timeout pulses 16 cycles after the last accept, busy drops, frame_out is unchanged.
  - A byte arriving on the terminal cycle prevents the timeout.
- Back-pressure and reset: hold in_valid high across a commit.
  - No byte is lost; the byte is taken the cycle after COMMIT.
  - Asserting rst_n low mid-LOAD restores RESET_IMAGE immediately.
